// File: rtl/hash_msg_driver.sv
// ---------------------------------------------------------------------------
// hash_msg_driver
//   Upstream feeder for the bent-function LFSR hash core. Message words come
//   in over a valid/ready stream and are shifted MSB-first onto the core's
//   single injector bit. After the message, the driver injects a '1' marker
//   bit, then the message bit-length (LEN_W bits, MSB-first), then
//   FLUSH_CYCLES zero bits. It then captures the core output as the digest.
//   The core runs with enable tied high, so it is held cleared whenever no
//   message is in flight.
//
// Ports
//   clk           single clock
//   reset         synchronous, active-low reset (0 = reset)
//   in_valid      message word valid
//   in_data       message word
//   in_last       final word of the message, qualified by in_valid
//   in_ready      word accepted when in_valid & in_ready
//   hash_clear    core reset, 1 = core held cleared
//   inj           core injector bit
//   digest_in     core output O
//   digest_valid  captured digest available
//   digest        captured digest
//   digest_ready  digest consumed when digest_valid & digest_ready
//   busy          high in every state except IDLE
//   err           one-cycle pulse on input underrun between words
// ---------------------------------------------------------------------------
module hash_msg_driver #(
  parameter int WORD_W       = 8,
  parameter int DIGEST_W     = 32,
  parameter int LEN_W        = 16,
  parameter int FLUSH_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                hash_clear,
  output logic                inj,
  input  logic [DIGEST_W-1:0] digest_in,
  output logic                digest_valid,
  output logic [DIGEST_W-1:0] digest,
  input  logic                digest_ready,
  output logic                busy,
  output logic                err
);

  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int LW = (LEN_W > 1) ? $clog2(LEN_W) : 1;
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_W - 1);
  localparam logic [LW-1:0] LEN_LAST   = LW'(LEN_W - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_PAD    = 3'd4;
  localparam logic [2:0] S_LENGTH = 3'd5;
  localparam logic [2:0] S_FLUSH  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]          state_q,  state_d;
  logic [WORD_W-1:0]   sr_q,     sr_d;
  logic                last_q,   last_d;
  logic [BW-1:0]       bit_q,    bit_d;
  logic [LEN_W-1:0]    len_q,    len_d;
  logic [LW-1:0]       lidx_q,   lidx_d;
  logic [FW-1:0]       fcnt_q,   fcnt_d;
  logic [DIGEST_W-1:0] digest_q, digest_d;

  logic in_ready_c;
  logic inj_c;
  logic err_c;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    last_d     = last_q;
    bit_d      = bit_q;
    len_d      = len_q;
    lidx_d     = lidx_q;
    fcnt_d     = fcnt_q;
    digest_d   = digest_q;
    in_ready_c = 1'b0;
    inj_c      = 1'b0;
    err_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Core is still held cleared here, so stalling costs nothing.
        in_ready_c = 1'b1;
        if (in_valid) begin
          sr_d    = in_data;
          last_d  = in_last;
          bit_d   = '0;
          len_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        inj_c = sr_q[WORD_W-1];
        sr_d  = sr_q << 1;
        bit_d = bit_q + 1'b1;
        if (len_q != '1) len_d = len_q + 1'b1;
        if (bit_q == BIT_LAST) begin
          if (last_q) begin
            state_d = S_PAD;
          end else begin
            // Next word must be ready on the last bit; a gap would inject
            // spurious bits into the free-running core.
            in_ready_c = 1'b1;
            if (in_valid) begin
              sr_d   = in_data;
              last_d = in_last;
              bit_d  = '0;
            end else begin
              err_c   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      S_PAD: begin
        inj_c   = 1'b1;
        lidx_d  = '0;
        state_d = S_LENGTH;
      end
      S_LENGTH: begin
        // len_q is no longer counting, so it doubles as the output shifter.
        inj_c  = len_q[LEN_W-1];
        len_d  = len_q << 1;
        lidx_d = lidx_q + 1'b1;
        if (lidx_q == LEN_LAST) begin
          fcnt_d  = '0;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == FLUSH_LAST) begin
          digest_d = digest_in;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (digest_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      digest_q <= digest_d;
    end
  end

  // Working registers are always (re)loaded before use, so they need no reset.
  always_ff @(posedge clk) begin
    sr_q   <= sr_d;
    last_q <= last_d;
    bit_q  <= bit_d;
    len_q  <= len_d;
    lidx_q <= lidx_d;
    fcnt_q <= fcnt_d;
  end

  assign in_ready     = in_ready_c;
  assign inj          = inj_c;
  assign err          = err_c;
  assign hash_clear   = (state_q == S_IDLE) || (state_q == S_CLEAR) ||
                        (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign digest_valid = (state_q == S_DONE);
  assign digest       = digest_q;

endmodule

// File: tb/tb_hash_msg_driver.sv
// ---------------------------------------------------------------------------
// tb_hash_msg_driver
//   Directed bench for hash_msg_driver (WORD_W=8, DIGEST_W=32, LEN_W=16,
//   FLUSH_CYCLES=64). digest_in changes every cycle so that the capture
//   cycle of the digest is observable.
// ---------------------------------------------------------------------------
module tb_hash_msg_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        hash_clear;
  logic        inj;
  logic [31:0] digest_in;
  logic        digest_valid;
  logic [31:0] digest;
  logic        digest_ready;
  logic        busy;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;
  int tick    = 0;

  hash_msg_driver #(
    .WORD_W(8), .DIGEST_W(32), .LEN_W(16), .FLUSH_CYCLES(64)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .hash_clear(hash_clear), .inj(inj),
    .digest_in(digest_in), .digest_valid(digest_valid), .digest(digest),
    .digest_ready(digest_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (tick %0d)", tag, got, exp, tick);
    end
  endtask

  // Advance one clock; outputs are settled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    tick++;
    digest_in = 32'hD1E5_0000 ^ 32'(tick);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_inj"},   {31'd0, inj}, 32'd0);
    chk({tag, "_dv"},    {31'd0, digest_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_err"},   {31'd0, err}, 32'd0);
    chk({tag, "_clr"},   {31'd0, hash_clear}, 32'd1);
  endtask

  // Send n words (n<=3), check the full injector stream and handshake timing,
  // then the digest. hold = cycles of digest backpressure; abort_at > 0
  // applies a one-cycle reset in that stream cycle instead of completing.
  task automatic run_msg(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input int n, input int hold,
                         input int abort_at);
    logic [7:0]  words [3];
    logic        exp_bits [256];
    logic [15:0] lenv;
    logic [31:0] exp_dig;
    int          nb, total, wi, t;
    words = '{w0, w1, w2};
    nb    = 8 * n;
    lenv  = 16'(nb);
    for (int k = 0; k < nb; k++) exp_bits[k] = words[k / 8][7 - (k % 8)];
    exp_bits[nb] = 1'b1;
    for (int j = 0; j < 16; j++) exp_bits[nb + 1 + j] = lenv[15 - j];
    for (int j = 0; j < 64; j++) exp_bits[nb + 17 + j] = 1'b0;
    total   = nb + 81;
    exp_dig = 32'd0;

    in_valid     = 1'b1;
    in_data      = words[0];
    in_last      = (n == 1);
    digest_ready = 1'b0;
    t = 0;
    while (!in_ready && t < 10) begin
      step();
      t++;
    end
    chk("load_ready", {31'd0, in_ready}, 32'd1);
    chk("load_clear", {31'd0, hash_clear}, 32'd1);

    for (int k = 1; k <= total; k++) begin
      step();
      wi       = (k - 1) / 8 + 1;
      in_valid = (wi < n);
      in_data  = words[(wi < n) ? wi : 0];
      in_last  = (wi == n - 1);
      #1;
      chk($sformatf("inj_c%0d", k), {31'd0, inj}, {31'd0, exp_bits[k - 1]});
      chk($sformatf("rdy_c%0d", k), {31'd0, in_ready},
          {31'd0, (k <= nb) && (k % 8 == 0) && (k < nb)});
      chk($sformatf("clr_c%0d", k), {31'd0, hash_clear}, 32'd0);
      chk($sformatf("dv_c%0d", k),  {31'd0, digest_valid}, 32'd0);
      chk($sformatf("busy_c%0d", k), {31'd0, busy}, 32'd1);
      chk($sformatf("err_c%0d", k), {31'd0, err}, 32'd0);
      if (k == total) exp_dig = digest_in;
      if (k == abort_at) begin
        reset = 1'b0;
        step();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_digest", digest, 32'd0);
        return;
      end
    end

    step();
    chk("done_dv", {31'd0, digest_valid}, 32'd1);
    chk("done_digest", digest, exp_dig);
    chk("done_ready", {31'd0, in_ready}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd1);
    for (int h = 0; h < hold; h++) begin
      step();
      chk($sformatf("hold%0d_digest", h), digest, exp_dig);
      chk($sformatf("hold%0d_dv", h), {31'd0, digest_valid}, 32'd1);
      chk($sformatf("hold%0d_ready", h), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_busy", h), {31'd0, busy}, 32'd1);
    end
    digest_ready = 1'b1;
    step();
    digest_ready = 1'b0;
    #1;
    chk_idle("post");
    chk("post_digest", digest, exp_dig);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b1;
    in_data      = 8'hFF;
    in_last      = 1'b1;
    digest_ready = 1'b0;
    digest_in    = 32'hD1E5_0000;

    // 1. reset with in_valid held high
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("rst%0d", i));
      chk($sformatf("rst%0d_digest", i), digest, 32'd0);
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    chk_idle("rel");

    // 2. single word 0xA5
    run_msg(8'hA5, 8'h00, 8'h00, 1, 0, 0);

    // 3. three words back-to-back
    run_msg(8'h01, 8'h02, 8'h03, 3, 0, 0);

    // 4. underrun after first word
    in_valid = 1'b1;
    in_data  = 8'h11;
    in_last  = 1'b0;
    for (int t = 0; t < 10 && !in_ready; t++) step();
    chk("ur_load", {31'd0, in_ready}, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      step();
      in_valid = 1'b0;
      #1;
      chk($sformatf("ur_err_c%0d", k), {31'd0, err}, {31'd0, k == 8});
      chk($sformatf("ur_inj_c%0d", k), {31'd0, inj},
          {31'd0, k == 4 || k == 8});
    end
    step();
    chk_idle("ur_idle");
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ur_dv%0d", i), {31'd0, digest_valid}, 32'd0);
      chk($sformatf("ur_busy%0d", i), {31'd0, busy}, 32'd0);
    end

    // 5. digest backpressure
    run_msg(8'h3C, 8'h00, 8'h00, 1, 10, 0);

    // 6. reset during LENGTH (stream cycle 12), then a fresh 0xA5
    run_msg(8'hA5, 8'h00, 8'h00, 1, 0, 12);
    run_msg(8'hA5, 8'h00, 8'h00, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hash_msg_driver.md
Name: hash_msg_driver

Overview:
- Upstream feeder for the bent-function LFSR hash top.
- Accepts message words over a valid/ready stream and serializes them MSB-first onto the hash core's single injector bit.
- Appends a '1' marker bit, a bit-length field and zero flush cycles, then captures the core's O output as the digest.
- Holds the core cleared while idle, because the core runs with enable tied high and injects one bit on every cycle.

Parameters:
- WORD_W, 8: message word width in bits.
- DIGEST_W, 32: width of core output O and of the digest.
- LEN_W, 16: width of the appended bit-length field.
- FLUSH_CYCLES, 64: zero-injection cycles before the digest is captured.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  message word valid.
- in_data  in  WORD_W  message word.
- in_last  in  1  marks the final word; qualified by in_valid.
- in_ready  out  1  word accepted when in_valid & in_ready.
- hash_clear  out  1  drives the core reset; 1 = core held cleared.
- inj  out  1  to core lfsr_in_injector.
- digest_in  in  DIGEST_W  core output O.
- digest_valid  out  1  digest available.
- digest  out  DIGEST_W  captured digest.
- digest_ready  in  1  digest consumed when digest_valid & digest_ready.
- busy  out  1  high in every state except IDLE.
- err  out  1  one-cycle underrun pulse.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE. Outputs in_ready=0, inj=0, digest_valid=0, digest=0, busy=0, err=0, hash_clear=1. Reset wins over every other event in every state.
- hash_clear=1 in IDLE, CLEAR and LOAD; 0 in all other states.
- inj=0 except in SHIFT, PAD and LENGTH.
- IDLE: in_ready=0. in_valid=1 -> CLEAR.
- CLEAR: exactly 1 cycle -> LOAD.
- LOAD: in_ready=1.
  - On handshake: shift register <= in_data, last_flag <= in_last, bit_cnt <= 0, len_cnt <= 0 -> SHIFT.
  - Waiting in LOAD is harmless because the core is held cleared.
- SHIFT: inj = shift register MSB; register shifts left each cycle.
  - len_cnt increments by 1 per bit and saturates at all-ones.
  - In the cycle with bit_cnt=WORD_W-1:
    - If last_flag=1 -> PAD; in_ready=0.
    - Else in_ready=1. On handshake, load the new word and flags, stay in SHIFT with bit_cnt=0, giving back-to-back words with no gap.
    - Else (in_valid=0): underrun. err=1 for that cycle -> IDLE; partial message discarded.
  - in_ready=0 in all other SHIFT cycles.
- PAD: inj=1 for 1 cycle -> LENGTH.
- LENGTH: LEN_W cycles; inj = len_cnt MSB-first -> FLUSH.
- FLUSH: FLUSH_CYCLES cycles with inj=0.
  - At the clock edge leaving the last FLUSH cycle: digest <= digest_in -> DONE.
- DONE: digest_valid=1; digest held stable; in_ready=0.
  - On digest_ready=1: at that edge digest_valid <= 0 -> IDLE. digest keeps its value.
- Latency: with handshake of the final single word in cycle 0, SHIFT occupies cycles 1..W, PAD W+1, LENGTH W+2..W+1+LEN_W, FLUSH the next FLUSH_CYCLES cycles. digest_valid rises in the following cycle.
- Counter widths:
  - bit_cnt: clog2(WORD_W).
  - len_cnt: LEN_W.
  - flush counter: clog2(FLUSH_CYCLES+1).
- A new message cannot start until the digest is consumed.
- in_data and in_last are ignored when no handshake occurs.

Test Plan (WORD_W=8, DIGEST_W=32, LEN_W=16, FLUSH_CYCLES=64):
1. Reset check:
   - Hold reset=0 three cycles with in_valid=1.
   - Required: in_ready=0, inj=0, digest_valid=0, digest=0, busy=0, err=0, hash_clear=1. State remains IDLE one cycle after release.
2. Single word 0xA5 with in_last=1, handshake in cycle 0:
   - inj over cycles 1..8 = 1,0,1,0,0,1,0,1.
   - Cycle 9: inj=1.
   - Cycles 10..25: inj = 0x0008 MSB-first.
   - Cycles 26..89: inj=0.
   - digest_valid=1 from cycle 90; digest = digest_in sampled at the end of cycle 89.
   - hash_clear=0 from cycle 1.
3. Words 0x01, 0x02, 0x03 back-to-back (in_last on 0x03):
   - in_ready pulses only in the last SHIFT cycle of each word.
   - Bit stream is 24 contiguous bits, then the 1 marker, then length 0x0018.
   - digest_valid in cycle 106.
4. Underrun: 0x11 accepted, in_valid=0 at its 8th bit:
   - err=1 in exactly that cycle.
   - IDLE next cycle with hash_clear=1 and digest_valid never asserted.
5. Digest backpressure: hold digest_ready=0 for 10 cycles in DONE:
   - digest is stable, in_ready=0 and busy=1 throughout.
   - digest_ready=1 -> IDLE the next cycle, digest_valid=0 and digest value retained.
6. Reset mid-operation: reset=0 for one cycle during LENGTH:
   - Next cycle shows IDLE reset values.
   - A fresh 0xA5 message then reproduces the scenario 2 timing exactly.
